// File: rtl/alu_decode.sv
// RV32I decode stage: turns an instruction plus register operands into a
// registered ALU command held in a one-entry valid/ready pipeline register.
module alu_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_fn,
    output logic [31:0] operandA,
    output logic [31:0] operandB,
    output logic        btype,
    output logic        bneq,
    output logic        illegal,
    output logic [15:0] dec_count
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] FN_ADD    = 4'b0000;
    localparam logic [3:0] FN_SLL    = 4'b0001;
    localparam logic [3:0] FN_SLT    = 4'b0010;
    localparam logic [3:0] FN_SLTU   = 4'b0011;
    localparam logic [3:0] FN_SRL    = 4'b0101;
    localparam logic [3:0] FN_SUB    = 4'b1000;
    localparam logic [3:0] FN_SGT    = 4'b1001;
    localparam logic [3:0] FN_UGT    = 4'b1010;
    localparam logic [3:0] FN_SRA    = 4'b1101;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immU;
    logic [31:0] w_shamt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_immI   = {{20{instr[31]}}, instr[31:20]};
    assign w_immS   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_immU   = {instr[31:12], 12'b0};
    assign w_shamt  = {27'b0, instr[24:20]};

    logic [3:0]  w_rawFn;
    logic [31:0] w_rawA;
    logic [31:0] w_rawB;
    logic        w_rawBtype;
    logic        w_rawBneq;
    logic        w_illegal;

    always_comb begin
        w_rawFn    = FN_ADD;
        w_rawA     = 32'b0;
        w_rawB     = 32'b0;
        w_rawBtype = 1'b0;
        w_rawBneq  = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            OP_REG: begin
                w_rawA = rs1_data;
                w_rawB = rs2_data;
                if (w_funct7 == F7_BASE) begin
                    w_rawFn = {1'b0, w_funct3};
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_rawFn = FN_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_rawFn = FN_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                w_rawA = rs1_data;
                if (w_funct3 == 3'b001) begin
                    w_rawB  = w_shamt;
                    w_rawFn = FN_SLL;
                end else if (w_funct3 == 3'b101) begin
                    w_rawB  = w_shamt;
                    w_rawFn = instr[30] ? FN_SRA : FN_SRL;
                end else begin
                    w_rawB  = w_immI;
                    w_rawFn = {1'b0, w_funct3};
                end
            end
            OP_LUI: begin
                w_rawB = w_immU;
            end
            OP_AUIPC: begin
                w_rawA = pc;
                w_rawB = w_immU;
            end
            OP_LOAD: begin
                w_rawA = rs1_data;
                w_rawB = w_immI;
            end
            OP_STORE: begin
                w_rawA = rs1_data;
                w_rawB = w_immS;
            end
            OP_JAL, OP_JALR: begin
                w_rawA = pc;
                w_rawB = 32'd4;
            end
            OP_BRANCH: begin
                w_rawA     = rs1_data;
                w_rawB     = rs2_data;
                w_rawBtype = 1'b1;
                // BGE/BGEU are evaluated as "greater than" by the ALU; the
                // branch unit combines that with equality on its side.
                case (w_funct3)
                    3'b000:  w_rawFn = FN_SUB;
                    3'b001: begin
                        w_rawFn   = FN_SUB;
                        w_rawBneq = 1'b1;
                    end
                    3'b100:  w_rawFn = FN_SLT;
                    3'b101:  w_rawFn = FN_SGT;
                    3'b110:  w_rawFn = FN_SLTU;
                    3'b111:  w_rawFn = FN_UGT;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    logic [3:0]  w_decFn;
    logic [31:0] w_decA;
    logic [31:0] w_decB;
    logic        w_decBtype;
    logic        w_decBneq;

    // An undecodable word still produces a command, but a fully neutral one.
    assign w_decFn    = w_illegal ? FN_ADD : w_rawFn;
    assign w_decA     = w_illegal ? 32'b0  : w_rawA;
    assign w_decB     = w_illegal ? 32'b0  : w_rawB;
    assign w_decBtype = w_illegal ? 1'b0   : w_rawBtype;
    assign w_decBneq  = w_illegal ? 1'b0   : w_rawBneq;

    logic        r_valid;
    logic [3:0]  r_fn;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic        r_btype;
    logic        r_bneq;
    logic        r_illegal;
    logic [15:0] r_count;
    logic        w_load;

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fn      <= FN_ADD;
            r_opA     <= 32'b0;
            r_opB     <= 32'b0;
            r_btype   <= 1'b0;
            r_bneq    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_fn      <= w_decFn;
            r_opA     <= w_decA;
            r_opB     <= w_decB;
            r_btype   <= w_decBtype;
            r_bneq    <= w_decBneq;
            r_illegal <= w_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'h0000;
        end else if (w_load) begin
            r_count <= r_count + 16'h0001;
        end
    end

    assign out_valid = r_valid;
    assign alu_fn    = r_fn;
    assign operandA  = r_opA;
    assign operandB  = r_opB;
    assign btype     = r_btype;
    assign bneq      = r_bneq;
    assign illegal   = r_illegal;
    assign dec_count = r_count;

endmodule

// File: tb/tb_alu_decode.sv
// Self-checking bench for alu_decode: directed vectors, randomized traffic
// against a mnemonic-level reference model, async reset and counter wrap.
module tb_alu_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_fn;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        btype;
    logic        bneq;
    logic        illegal;
    logic [15:0] dec_count;

    alu_decode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .pc        (pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_fn    (alu_fn),
        .operandA  (operandA),
        .operandB  (operandB),
        .btype     (btype),
        .bneq      (bneq),
        .illegal   (illegal),
        .dec_count (dec_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic        btype;
        logic        bneq;
        logic        illegal;
    } cmd_t;

    int          nVectors = 0;
    int          nMiscompares = 0;
    logic        mValid;
    logic        mKnown;
    cmd_t        mCmd;
    logic [15:0] mCount;

    // Reference model: name the instruction first, then derive the command.
    function automatic string baseOp(input logic [2:0] f3);
        case (f3)
            3'd0:    return "add";
            3'd1:    return "sll";
            3'd2:    return "slt";
            3'd3:    return "sltu";
            3'd4:    return "xor";
            3'd5:    return "srl";
            3'd6:    return "or";
            default: return "and";
        endcase
    endfunction

    function automatic string mnemonic(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00) return baseOp(f3);
                if (f7 == 7'h20 && f3 == 3'd0) return "sub";
                if (f7 == 7'h20 && f3 == 3'd5) return "sra";
                return "ill";
            end
            7'h13: begin
                if (f3 == 3'd5) return ins[30] ? "srai" : "srli";
                return {baseOp(f3), "i"};
            end
            7'h37: return "lui";
            7'h17: return "auipc";
            7'h03: return "load";
            7'h23: return "store";
            7'h6F: return "jal";
            7'h67: return "jalr";
            7'h63: begin
                case (f3)
                    3'd0:    return "beq";
                    3'd1:    return "bne";
                    3'd4:    return "blt";
                    3'd5:    return "bge";
                    3'd6:    return "bltu";
                    3'd7:    return "bgeu";
                    default: return "ill";
                endcase
            end
            default: return "ill";
        endcase
    endfunction

    function automatic logic [3:0] opFn(input string op);
        if (op == "add")  return 4'd0;
        if (op == "sll")  return 4'd1;
        if (op == "slt")  return 4'd2;
        if (op == "sltu") return 4'd3;
        if (op == "xor")  return 4'd4;
        if (op == "srl")  return 4'd5;
        if (op == "or")   return 4'd6;
        if (op == "and")  return 4'd7;
        if (op == "sub")  return 4'd8;
        if (op == "sgt")  return 4'd9;
        if (op == "ugt")  return 4'd10;
        if (op == "sra")  return 4'd13;
        return 4'hF;
    endfunction

    function automatic cmd_t decodeModel(input logic [31:0] ins, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic [31:0] p);
        cmd_t        c;
        string       m;
        string       op;
        logic [31:0] iImm;
        logic [31:0] sImm;
        logic [31:0] uImm;
        logic [31:0] shamt;
        c     = '0;
        m     = mnemonic(ins);
        iImm  = 32'($signed(ins) >>> 20);
        sImm  = (iImm & ~32'h1F) | ((ins >> 7) & 32'h1F);
        uImm  = ins & 32'hFFFFF000;
        shamt = (ins >> 20) & 32'h1F;
        if (m == "ill") begin
            c.illegal = 1'b1;
        end else if (m == "lui") begin
            c.b = uImm;
        end else if (m == "auipc") begin
            c.a = p; c.b = uImm;
        end else if (m == "load") begin
            c.a = r1; c.b = iImm;
        end else if (m == "store") begin
            c.a = r1; c.b = sImm;
        end else if (m == "jal" || m == "jalr") begin
            c.a = p; c.b = 32'd4;
        end else if (ins[6:0] == 7'h63) begin
            c.a = r1; c.b = r2; c.btype = 1'b1;
            c.bneq = (m == "bne");
            if (m == "beq" || m == "bne") c.fn = opFn("sub");
            else if (m == "blt")          c.fn = opFn("slt");
            else if (m == "bge")          c.fn = opFn("sgt");
            else if (m == "bltu")         c.fn = opFn("sltu");
            else                          c.fn = opFn("ugt");
        end else if (ins[6:0] == 7'h13) begin
            op  = m.substr(0, m.len() - 2);
            c.a = r1;
            c.b = (op == "sll" || op == "srl" || op == "sra") ? shamt : iImm;
            c.fn = opFn(op);
        end else begin
            c.a = r1; c.b = r2; c.fn = opFn(m);
        end
        return c;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0:       r[31:25] = 7'h00;
                    1:       r[31:25] = 7'h20;
                    default: r[31:25] = 7'($urandom);
                endcase
            end
            1:  r[6:0] = 7'h13;
            2:  r[6:0] = 7'h37;
            3:  r[6:0] = 7'h17;
            4:  r[6:0] = 7'h03;
            5:  r[6:0] = 7'h23;
            6:  r[6:0] = 7'h6F;
            7:  r[6:0] = 7'h67;
            8, 9: r[6:0] = 7'h63;
            10: r = r;
            default: begin
                r[6:0] = 7'h33;
                r[31:25] = 7'h00;
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        assert (got === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("dec_count", 32'(dec_count), 32'(mCount));
        if (mKnown) begin
            checkOutput("alu_fn",   32'(alu_fn),  32'(mCmd.fn));
            checkOutput("operandA", operandA,     mCmd.a);
            checkOutput("operandB", operandB,     mCmd.b);
            checkOutput("btype",    32'(btype),   32'(mCmd.btype));
            checkOutput("bneq",     32'(bneq),    32'(mCmd.bneq));
            checkOutput("illegal",  32'(illegal), 32'(mCmd.illegal));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_illegal"},   32'(illegal),   32'd0);
        checkOutput({tag, "_btype"},     32'(btype),     32'd0);
        checkOutput({tag, "_bneq"},      32'(bneq),      32'd0);
        checkOutput({tag, "_alu_fn"},    32'(alu_fn),    32'd0);
        checkOutput({tag, "_operandA"},  operandA,       32'd0);
        checkOutput({tag, "_operandB"},  operandB,       32'd0);
        checkOutput({tag, "_dec_count"}, 32'(dec_count), 32'd0);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mKnown = 1'b1;
        mCmd   = '0;
        mCount = 16'h0000;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] p,
                                 input logic fl, input logic ordy);
        in_valid  = v;
        instr     = ins;
        rs1_data  = a;
        rs2_data  = b;
        pc        = p;
        flush     = fl;
        out_ready = ordy;
    endtask

    // One clock: check handshake before the edge, advance model, check after.
    task automatic cycle();
        logic ready;
        logic load;
        cmd_t next;
        #1;
        ready = !mValid || out_ready;
        checkOutput("in_ready", 32'(in_ready), 32'(ready));
        load = in_valid && ready && !flush;
        next = decodeModel(instr, rs1_data, rs2_data, pc);
        @(posedge clk);
        if (flush) begin
            mValid = 1'b0;
        end else if (load) begin
            mValid = 1'b1;
            mCmd   = next;
            mCount = mCount + 16'h0001;
        end else if (out_ready) begin
            mValid = 1'b0;
        end
        mKnown = mValid;
        #1;
        checkAll();
    endtask

    initial begin
        logic [15:0] savedCount;
        int          pumps;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        modelReset();
        #2;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 32'h403100B3, 32'd7, 32'd9, 32'h100, 1'b0, 1'b1);
        cycle();
        checkOutput("sub_valid", 32'(out_valid), 32'd1);
        checkOutput("sub_fn",    32'(alu_fn),    32'h8);
        checkOutput("sub_A",     operandA,       32'd7);
        checkOutput("sub_B",     operandB,       32'd9);
        checkOutput("sub_btype", 32'(btype),     32'd0);

        applyStimulus(1'b1, 32'h40515093, 32'h80000000, 32'd0, 32'h104, 1'b0, 1'b1);
        cycle();
        checkOutput("srai_fn", 32'(alu_fn), 32'hD);
        checkOutput("srai_B",  operandB,    32'h00000005);

        applyStimulus(1'b1, 32'hFFF10093, 32'd5, 32'd0, 32'h108, 1'b0, 1'b1);
        cycle();
        checkOutput("addi_fn", 32'(alu_fn), 32'h0);
        checkOutput("addi_B",  operandB,    32'hFFFFFFFF);

        applyStimulus(1'b1, 32'h00209463, 32'd3, 32'd3, 32'h10C, 1'b0, 1'b1);
        cycle();
        checkOutput("bne_fn",    32'(alu_fn), 32'h8);
        checkOutput("bne_btype", 32'(btype),  32'd1);
        checkOutput("bne_bneq",  32'(bneq),   32'd1);

        applyStimulus(1'b1, 32'h0020F463, 32'd3, 32'd3, 32'h110, 1'b0, 1'b1);
        cycle();
        checkOutput("bgeu_fn",    32'(alu_fn), 32'hA);
        checkOutput("bgeu_btype", 32'(btype),  32'd1);
        checkOutput("bgeu_bneq",  32'(bneq),   32'd0);

        // Backpressure: hold a second command while the first is stalled.
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle();
        savedCount = dec_count;
        applyStimulus(1'b1, 32'h002081B3, 32'h11, 32'h22, 32'h200, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 32'h0020C233, 32'h33, 32'h44, 32'h204, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_A",        operandA,      32'h11);
        end
        out_ready = 1'b1;
        cycle();
        checkOutput("resume_A", operandA, 32'h33);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle();
        checkOutput("stall_count", 32'(dec_count), 32'(savedCount + 16'd2));

        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h300, 1'b0, 1'b1);
        cycle();
        checkOutput("ill_flag", 32'(illegal), 32'd1);
        checkOutput("ill_fn",   32'(alu_fn),  32'd0);
        checkOutput("ill_A",    operandA,     32'd0);
        checkOutput("ill_B",    operandB,     32'd0);

        savedCount = dec_count;
        applyStimulus(1'b1, 32'h00108093, 32'h1, 32'h1, 32'h304, 1'b1, 1'b0);
        cycle();
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_count", 32'(dec_count), 32'(savedCount));

        // Asynchronous reset in the middle of a held transfer.
        applyStimulus(1'b1, 32'h00F00313, 32'h1234, 32'h0, 32'h308, 1'b0, 1'b0);
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checkResetState("async_rst");
        modelReset();
        @(posedge clk);
        #1;
        checkResetState("rst_held");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom, $urandom, $urandom,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            cycle();
        end

        // Fill the counter to 0xFFFF, then one more load must wrap it.
        pumps = 32'hFFFF - int'(mCount);
        applyStimulus(1'b1, 32'h00A00093, 32'h9, 32'h0, 32'h400, 1'b0, 1'b1);
        repeat (pumps) @(posedge clk);
        #1;
        mCount = 16'hFFFF;
        mValid = 1'b1;
        mKnown = 1'b1;
        mCmd   = decodeModel(32'h00A00093, 32'h9, 32'h0, 32'h400);
        checkAll();
        checkOutput("full_count", 32'(dec_count), 32'h0000FFFF);
        cycle();
        checkOutput("wrap_count", 32'(dec_count), 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
